// File: rtl/hsv_rgb_pwm.sv
// HSV to 8-bit RGB converter (multi-cycle FSM, shared restoring divider) driving three PWM LED outputs.
// Define HSV_PWM_INVERT_EN for active-low (common-anode) LED outputs.
module hsv_rgb_pwm #(
  parameter int PWM_BITS = 8,
  parameter int PWM_DIV  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] Hue,
  input  logic [8:0] Saturation,
  input  logic [8:0] Value,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       busy,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b
);

  typedef enum logic [2:0] {IDLE, SAMPLE, CALC, DIVX, DIVR, DIVG, DIVB, LOAD} state_t;

  state_t      state;
  logic        valid;
  logic [8:0]  h_reg, last_h;
  logic [6:0]  s_reg, v_reg, last_s, last_v;
  logic [13:0] c_reg, m_reg, comp_g_reg, comp_b_reg;
  logic [2:0]  sector_reg;
  logic [21:0] dvd_reg;
  logic [13:0] rem_reg, divisor_reg;
  logic [4:0]  iter;
  logic [7:0]  r_q, g_q, b_q;

  // Clamp inputs to their legal ranges before comparing or sampling
  logic [8:0] h_clamp;
  logic [6:0] s_clamp, v_clamp;
  assign h_clamp = (Hue > 9'd359) ? 9'd359 : Hue;
  assign s_clamp = (Saturation > 9'd100) ? 7'd100 : Saturation[6:0];
  assign v_clamp = (Value > 9'd100) ? 7'd100 : Value[6:0];

  logic [13:0] c_calc, m_calc;
  logic [2:0]  sector_calc;
  logic [8:0]  base_calc;
  logic [5:0]  f_calc, k_calc;
  logic [21:0] dvd_x;

  assign c_calc = 14'(v_reg) * 14'(s_reg);
  assign m_calc = 14'(v_reg) * 14'd100 - c_calc;

  always_comb begin
    sector_calc = 3'd5;
    base_calc   = 9'd300;
    if (h_reg < 9'd60)       begin sector_calc = 3'd0; base_calc = 9'd0;   end
    else if (h_reg < 9'd120) begin sector_calc = 3'd1; base_calc = 9'd60;  end
    else if (h_reg < 9'd180) begin sector_calc = 3'd2; base_calc = 9'd120; end
    else if (h_reg < 9'd240) begin sector_calc = 3'd3; base_calc = 9'd180; end
    else if (h_reg < 9'd300) begin sector_calc = 3'd4; base_calc = 9'd240; end
  end

  assign f_calc = 6'(h_reg - base_calc);
  assign k_calc = sector_calc[0] ? (6'd60 - f_calc) : f_calc;
  assign dvd_x  = 22'(c_calc) * 22'(k_calc);

  // One restoring step: quotient bits shift into the dividend register from the right
  logic [14:0] trial, diff;
  logic        ge;
  logic [13:0] rem_next;
  logic [21:0] dvd_next;
  logic        last_iter;
  assign trial     = {rem_reg, dvd_reg[21]};
  assign diff      = trial - {1'b0, divisor_reg};
  assign ge        = ~diff[14];
  assign rem_next  = ge ? diff[13:0] : trial[13:0];
  assign dvd_next  = {dvd_reg[20:0], ge};
  assign last_iter = (iter == 5'd21);

  logic [13:0] x_q, map_r, map_g, map_b, comp_r, comp_g, comp_b;
  assign x_q = dvd_next[13:0];

  always_comb begin
    map_r = '0;
    map_g = '0;
    map_b = '0;
    case (sector_reg)
      3'd0:    begin map_r = c_reg; map_g = x_q;   end
      3'd1:    begin map_r = x_q;   map_g = c_reg; end
      3'd2:    begin map_g = c_reg; map_b = x_q;   end
      3'd3:    begin map_g = x_q;   map_b = c_reg; end
      3'd4:    begin map_r = x_q;   map_b = c_reg; end
      default: begin map_r = c_reg; map_b = x_q;   end
    endcase
  end

  assign comp_r = map_r + m_reg;
  assign comp_g = map_g + m_reg;
  assign comp_b = map_b + m_reg;

  function automatic logic [21:0] scale(input logic [13:0] comp);
    return 22'(comp) * 22'd255 + 22'd5000;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= 1'b0;
      busy        <= 1'b0;
      h_reg       <= '0;
      s_reg       <= '0;
      v_reg       <= '0;
      last_h      <= '0;
      last_s      <= '0;
      last_v      <= '0;
      c_reg       <= '0;
      m_reg       <= '0;
      comp_g_reg  <= '0;
      comp_b_reg  <= '0;
      sector_reg  <= '0;
      dvd_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      iter        <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!valid || h_clamp != last_h || s_clamp != last_s || v_clamp != last_v) begin
            state <= SAMPLE;
            busy  <= 1'b1;
          end
        end
        SAMPLE: begin
          h_reg <= h_clamp;
          s_reg <= s_clamp;
          v_reg <= v_clamp;
          state <= CALC;
        end
        CALC: begin
          c_reg       <= c_calc;
          m_reg       <= m_calc;
          sector_reg  <= sector_calc;
          dvd_reg     <= dvd_x;
          rem_reg     <= '0;
          divisor_reg <= 14'd60;
          iter        <= '0;
          state       <= DIVX;
        end
        DIVX, DIVR, DIVG, DIVB: begin
          dvd_reg <= dvd_next;
          rem_reg <= rem_next;
          iter    <= iter + 5'd1;
          // Final step: capture the quotient and preload the next division
          if (last_iter) begin
            rem_reg <= '0;
            iter    <= '0;
            case (state)
              DIVX: begin
                comp_g_reg  <= comp_g;
                comp_b_reg  <= comp_b;
                dvd_reg     <= scale(comp_r);
                divisor_reg <= 14'd10000;
                state       <= DIVR;
              end
              DIVR: begin
                r_q     <= dvd_next[7:0];
                dvd_reg <= scale(comp_g_reg);
                state   <= DIVG;
              end
              DIVG: begin
                g_q     <= dvd_next[7:0];
                dvd_reg <= scale(comp_b_reg);
                state   <= DIVB;
              end
              default: begin
                b_q   <= dvd_next[7:0];
                state <= LOAD;
              end
            endcase
          end
        end
        default: begin
          r      <= r_q;
          g      <= g_q;
          b      <= b_q;
          last_h <= h_reg;
          last_s <= s_reg;
          last_v <= v_reg;
          valid  <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // PWM: prescaled free-running counter, duties resampled only at the 255->0 wrap
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

`ifdef HSV_PWM_INVERT_EN
  localparam logic LED_OFF = 1'b1;
`else
  localparam logic LED_OFF = 1'b0;
`endif

  logic [PW-1:0]       presc;
  logic [PWM_BITS-1:0] cnt;
  logic                tick, wrap;
  assign tick = (presc == PW'(PWM_DIV - 1));
  assign wrap = tick && (&cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
    end
  end

  logic [7:0] rgb_arr [3];
  logic       led_arr [3];
  assign rgb_arr[0] = r;
  assign rgb_arr[1] = g;
  assign rgb_arr[2] = b;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [PWM_BITS-1:0] duty;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          duty        <= '0;
          led_arr[gi] <= LED_OFF;
        end else begin
          if (wrap) duty <= PWM_BITS'(rgb_arr[gi]);
          led_arr[gi] <= (cnt < duty) ^ LED_OFF;
        end
      end
    end
  endgenerate

  assign led_r = led_arr[0];
  assign led_g = led_arr[1];
  assign led_b = led_arr[2];

endmodule

// File: tb/tb_hsv_rgb_pwm.sv
// Scoreboard bench for hsv_rgb_pwm: stimulus pushes expected RGB, a monitor pops on each completed conversion.
module tb_hsv_rgb_pwm;

  logic       clk;
  logic       reset;
  logic [8:0] Hue, Saturation, Value;
  logic [7:0] r, g, b;
  logic       busy, led_r, led_g, led_b;

`ifdef HSV_PWM_INVERT_EN
  localparam logic LED_OFF = 1'b1;
`else
  localparam logic LED_OFF = 1'b0;
`endif

  hsv_rgb_pwm #(.PWM_BITS(8), .PWM_DIV(1)) dut (
    .clk(clk), .reset(reset), .Hue(Hue), .Saturation(Saturation), .Value(Value),
    .r(r), .g(g), .b(b), .busy(busy), .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];
  int          busy_len = 0;
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Monitor: a busy falling edge marks a completed conversion
  always @(negedge clk) begin
    logic [23:0] e;
    if (reset) begin
      busy_len  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) busy_len++;
      else if (prev_busy) begin
        check("busy_cycles", busy_len, 91);
        check("queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("conversion: rgb=(%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   r, g, b, e[23:16], e[15:8], e[7:0]);
          check("r", r, e[23:16]);
          check("g", g, e[15:8]);
          check("b", b, e[7:0]);
        end
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_done(input int n_left);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      if (exp_q.size() <= n_left) done = 1;
    end
    if (!done) begin
      check("done_timeout", exp_q.size(), n_left);
      exp_q.delete();
    end
  endtask

  task automatic wait_busy();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    if (!seen) check("busy_rise_timeout", busy, 1);
  endtask

  task automatic drive(input int h, input int s, input int v);
    @(negedge clk);
    Hue = 9'(h);
    Saturation = 9'(s);
    Value = 9'(v);
  endtask

  task automatic apply(input int h, input int s, input int v, input logic [23:0] rgb);
    drive(h, s, v);
    exp_q.push_back(rgb);
    wait_done(0);
  endtask

  task automatic count_active(input int n, output int cr, output int cg, output int cb);
    cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (led_r ^ LED_OFF) cr++;
      if (led_g ^ LED_OFF) cg++;
      if (led_b ^ LED_OFF) cb++;
    end
  endtask

  initial begin
    int cr, cg, cb, pre, run;
    logic a, prev;
    bit found;

    reset = 1'b1;
    Hue = 9'd0; Saturation = 9'd100; Value = 9'd100;
    exp_q.push_back(24'hFF0000);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rgb", {r, g, b}, 0);
    check("rst_led_r", led_r, LED_OFF);
    check("rst_led_g", led_g, LED_OFF);
    check("rst_led_b", led_b, LED_OFF);
    reset = 1'b0;
    @(negedge clk);
    check("busy_after_release", busy, 1);
    wait_done(0);

    apply(120, 100, 100, {8'd0,   8'd255, 8'd0});
    apply(240, 100, 100, {8'd0,   8'd0,   8'd255});
    apply(30,  100, 100, {8'd255, 8'd128, 8'd0});
    apply(300, 100, 100, {8'd255, 8'd0,   8'd255});
    apply(77,  0,   50,  {8'd128, 8'd128, 8'd128});
    apply(200, 0,   50,  {8'd128, 8'd128, 8'd128});
    apply(200, 0,   0,   {8'd0,   8'd0,   8'd0});
    apply(400, 100, 100, {8'd255, 8'd0,   8'd4});
    apply(240, 120, 100, {8'd0,   8'd0,   8'd255});
    apply(60,  100, 100, {8'd255, 8'd255, 8'd0});
    apply(180, 50,  80,  {8'd102, 8'd204, 8'd204});

    // PWM duty 255 / 0, then 64 on all channels
    apply(0, 100, 100, {8'd255, 8'd0, 8'd0});
    repeat (512) @(negedge clk);
    count_active(256, cr, cg, cb);
    check("pwm255_r", cr, 255);
    check("pwm0_g", cg, 0);
    check("pwm0_b", cb, 0);

    apply(0, 0, 25, {8'd64, 8'd64, 8'd64});
    repeat (512) @(negedge clk);
    count_active(256, cr, cg, cb);
    check("pwm64_r", cr, 64);
    check("pwm64_g", cg, 64);
    check("pwm64_b", cb, 64);

    // New duty must wait for the wrap: old 64 before it, full 128 pulse after
    apply(0, 0, 50, {8'd128, 8'd128, 8'd128});
    pre = 0; found = 0;
    @(negedge clk);
    prev = led_r ^ LED_OFF;
    if (prev) pre++;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      a = led_r ^ LED_OFF;
      if (a && !prev) found = 1;
      else if (a) pre++;
      prev = a;
    end
    check("wrap_found", found, 1);
    check("pre_wrap_le64", 32'(pre <= 64), 1);
    run = 1;
    for (int i = 0; i < 300 && (led_r ^ LED_OFF); i++) begin
      @(negedge clk);
      if (led_r ^ LED_OFF) run++;
    end
    check("post_wrap_pulse", run, 128);

    // Input change mid-conversion is picked up one idle cycle after LOAD
    drive(90, 100, 100);
    exp_q.push_back({8'd128, 8'd255, 8'd0});
    wait_busy();
    repeat (9) @(negedge clk);
    Hue = 9'd210;
    exp_q.push_back({8'd0, 8'd128, 8'd255});
    wait_done(1);
    @(negedge clk);
    check("gap_one_cycle", busy, 1);
    wait_done(0);

    // Reset at cycle 40 of a conversion, then a fresh conversion
    drive(120, 100, 100);
    wait_busy();
    repeat (39) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rgb", {r, g, b}, 0);
    check("midrst_led_r", led_r, LED_OFF);
    repeat (3) @(negedge clk);
    exp_q.push_back({8'd0, 8'd255, 8'd0});
    reset = 1'b0;
    @(negedge clk);
    check("busy_after_midrst", busy, 1);
    wait_done(0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hsv_rgb_pwm.md
# hsv_rgb_pwm

Consumer end of the HSV control interface: accepts Hue (0..359), Saturation (0..100) and Value (0..100) from the button/switch front end. Converts them to 8-bit RGB with a multi-cycle FSM and a shared sequential divider. Drives three PWM outputs for an RGB LED. Sits between the HSV front end and the board LED pins.

## Interface
- `PWM_BITS`, default 8: PWM counter width; fixed at 8, matching the RGB width.
- `PWM_DIV`, default 16: prescaler. The PWM counter advances once every `PWM_DIV` clk cycles. Must be ≥1.
- `clk` in 1: system clock.
- `reset` in 1: **asynchronous, active-high** reset.
- `Hue` in 9: hue in degrees, 0..359.
- `Saturation` in 9: saturation in percent, 0..100.
- `Value` in 9: value (brightness) in percent, 0..100.
- `r`, `g`, `b` out 8 each: converted colour, registered.
- `busy` out 1: high while a conversion is in progress.
- `led_r`, `led_g`, `led_b` out 1 each: PWM drive outputs.

## Operation
- **Input clamping.** Inputs are clamped when sampled:
  - Hue > 359 → 359.
  - Saturation > 100 → 100.
  - Value > 100 → 100.
- **FSM states:** IDLE, SAMPLE, CALC, DIVX, DIVR, DIVG, DIVB, LOAD.
- **IDLE:**
  - Go to SAMPLE if `valid`=0, or if any clamped input differs from the stored last-converted H/S/V.
  - `valid` is cleared by reset and set in LOAD.
- **SAMPLE:** latch clamped H, S, V. Input changes after this point are ignored until the return to IDLE.
- **CALC** (all integers, scale 10000):
  - C = V·S.
  - m = V·100 − C.
  - sector = H/60, computed by a compare chain against 60/120/180/240/300.
  - f = H − 60·sector.
  - k = f for even sectors, 60−f for odd sectors.
- **DIVX:** X = floor(C·k / 60).
- **Sector mapping** (values before adding m):
  - Sector 0: (C, X, 0)
  - Sector 1: (X, C, 0)
  - Sector 2: (0, C, X)
  - Sector 3: (0, X, C)
  - Sector 4: (X, 0, C)
  - Sector 5: (C, 0, X)
  - Each component comp = mapped value + m, range 0..10000.
- **DIVR / DIVG / DIVB:** each channel = floor((comp·255 + 5000) / 10000), range 0..255.
- **Divider:** one shared restoring divider with a 22-bit dividend. It always runs exactly 22 iterations, one quotient bit per cycle, for every division.
- **LOAD:** write `r`, `g`, `b`, store the last-converted H/S/V, set `valid`, return to IDLE.
- **PWM counter:** a free-running 8-bit counter advances on each prescaler tick.
- **Duty registers:** per-channel duty registers copy `r`/`g`/`b` only on the tick where the counter wraps 255→0. This prevents mid-period glitches.
- **PWM outputs:** `led_x` = (cnt < duty_x), registered.
  - duty 0 → output always inactive.
  - duty 255 → output active 255 of 256 counts.

## Timing
- **Reset values:** `r`=`g`=`b`=0, duties 0, cnt 0, prescaler 0, `busy`=0, `valid`=0, `led_*`=0 (1 with inversion; see Configuration), FSM in IDLE.
- **Conversion latency:** SAMPLE 1 + CALC 1 + 4×22 + LOAD 1 = 91 cycles.
  - `busy` is high from the SAMPLE cycle through the LOAD cycle, exactly 91 cycles.
  - `r`/`g`/`b` update at the end of LOAD.
- **After reset:** the first conversion enters SAMPLE on the first clk edge after `reset` deasserts.
- **Back-to-back:** after LOAD, IDLE compares inputs on the next cycle. Minimum gap between conversions is 1 idle cycle.
- **Input changes during a conversion:** picked up by that comparison, never lost.
- **Reset mid-conversion:** all state clears immediately and asynchronously. A fresh conversion follows release.
- **LED update delay:** a new RGB reaches `led_*` at the next counter wrap. Worst case is 256·`PWM_DIV` cycles.
- **PWM period:** 256·`PWM_DIV` clk cycles.

## Configuration
- `HSV_PWM_INVERT_EN`:
  - Defined: `led_*` are active-low for a common-anode LED. `led_x` = !(cnt < duty_x) and resets to 1.
  - Undefined: `led_*` are active-high and reset to 0.
- The conversion path is identical in both modes.

## Test plan
- Reset, then H=0, S=100, V=100 → `busy` high exactly 91 cycles, then rgb=(255,0,0). H=120 → (0,255,0); H=240 → (0,0,255).
- H=30, S=100, V=100 → rgb=(255,128,0). H=300 → (255,0,255).
- S=0, V=50, any H → rgb=(128,128,128). V=0 → (0,0,0).
- Out-of-range inputs: H=400, S=100, V=100 → same result as H=359, rgb=(255,0,4). S=120 → treated as 100.
- PWM with `PWM_DIV`=1, r=64 → `led_r` high 64 of every 256 cycles. Changing r mid-period takes effect only after the wrap. Repeat with `HSV_PWM_INVERT_EN` defined → `led_r` low 64 of 256, and 1 during reset.
- Assert `reset` at cycle 40 of a conversion → `busy`=0 and rgb=0 immediately. After release, a new 91-cycle conversion completes with the correct result. Changing H at cycle 10 of a conversion → a second conversion starts 1 cycle after LOAD.
